bp_fe_mem_sched: RTL and testbench

Front-end memory command scheduler that sits between the PC generator / FE command queue and the two-stage FE memory pipeline (ITLB + I$).
- Arbitrates fetch, ITLB fill and ITLB fence commands onto the single mem command port.
- Tracks in-flight fetches and drives poison.
- Sequences stall and replay on ITLB miss and I$ miss, and holds on faults.

---
 rtl/bp_fe_mem_sched.sv | 173 +++++++++++++++++
 tb/tb_bp_fe_mem_sched.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_mem_sched.sv
`default_nettype none
// ============================================================================
// Module : bp_fe_mem_sched
// Desc   : FE memory command scheduler. Arbitrates fence/fill/fetch onto the
//          mem command port, tracks the two-stage fetch pipe, sequences
//          ITLB-miss / I$-miss replay and holds on faults until redirect.
// Rev    : 1.0 - initial release
// ============================================================================
module bp_fe_mem_sched #(
    parameter int VADDR_WIDTH      = 39,
    parameter int VTAG_WIDTH       = 27,
    parameter int FILL_ENTRY_WIDTH = 64
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        fetch_v_i,
    input  logic [VADDR_WIDTH-1:0]      fetch_vaddr_i,
    output logic                        fetch_yumi_o,
    input  logic                        fill_v_i,
    input  logic [VTAG_WIDTH-1:0]       fill_vtag_i,
    input  logic [FILL_ENTRY_WIDTH-1:0] fill_entry_i,
    output logic                        fill_yumi_o,
    input  logic                        fence_v_i,
    output logic                        fence_yumi_o,
    input  logic                        redirect_i,
    output logic                        mem_cmd_v_o,
    output logic [1:0]                  mem_cmd_op_o,
    output logic [VADDR_WIDTH-1:0]      mem_cmd_vaddr_o,
    output logic [VTAG_WIDTH-1:0]       mem_cmd_vtag_o,
    output logic [FILL_ENTRY_WIDTH-1:0] mem_cmd_entry_o,
    input  logic                        mem_cmd_yumi_i,
    output logic                        mem_poison_o,
    input  logic                        mem_resp_v_i,
    input  logic                        mem_resp_itlb_miss_i,
    input  logic                        mem_resp_icache_miss_i,
    input  logic                        mem_resp_fault_i,
    input  logic                        cache_req_complete_i,
    output logic                        itlb_miss_v_o,
    output logic                        fault_v_o,
    output logic [VADDR_WIDTH-1:0]      miss_vaddr_o,
    output logic                        busy_o
);

    localparam logic [2:0] ST_RUN       = 3'd0;
    localparam logic [2:0] ST_WAIT_FILL = 3'd1;
    localparam logic [2:0] ST_WAIT_MISS = 3'd2;
    localparam logic [2:0] ST_REPLAY    = 3'd3;
    localparam logic [2:0] ST_HOLD      = 3'd4;

    localparam logic [1:0] OP_FETCH = 2'd0;
    localparam logic [1:0] OP_FILL  = 2'd1;
    localparam logic [1:0] OP_FENCE = 2'd2;

    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic                   r_s1_v;
    logic                   r_s2_v;
    logic [VADDR_WIDTH-1:0] r_s1_vaddr;
    logic [VADDR_WIDTH-1:0] r_s2_vaddr;
    logic [VADDR_WIDTH-1:0] r_miss_vaddr;
    logic                   r_cmpl_pend;

    logic w_resp;
    logic w_fault;
    logic w_itlb;
    logic w_icmiss;
    logic w_kill;
    logic w_fetch_slot;
    logic w_fetch_acc;

    // Responses are only meaningful for an occupied stage 2; redirect drops them.
    assign w_resp   = !reset_i && !redirect_i && r_s2_v && mem_resp_v_i;
    assign w_fault  = w_resp && mem_resp_fault_i;
    assign w_itlb   = w_resp && !mem_resp_fault_i && mem_resp_itlb_miss_i;
    assign w_icmiss = w_resp && !mem_resp_fault_i && !mem_resp_itlb_miss_i
                      && mem_resp_icache_miss_i;
    assign w_kill   = w_fault || w_itlb || w_icmiss;

    assign w_fetch_slot = ((r_state == ST_RUN) && fetch_v_i) || (r_state == ST_REPLAY);

    assign mem_cmd_vaddr_o = (r_state == ST_REPLAY) ? r_miss_vaddr : fetch_vaddr_i;
    assign mem_cmd_vtag_o  = fill_vtag_i;
    assign mem_cmd_entry_o = fill_entry_i;

    assign mem_poison_o  = !reset_i && (redirect_i || w_kill);
    assign itlb_miss_v_o = w_itlb;
    assign fault_v_o     = w_fault;
    // Present the faulting address alongside the notification pulse.
    assign miss_vaddr_o  = w_kill ? r_s2_vaddr : r_miss_vaddr;
    assign busy_o        = !reset_i && (r_s1_v || r_s2_v || (r_state != ST_RUN));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_WAIT_FILL: if (fill_yumi_o) w_state_nxt = ST_REPLAY;
            ST_WAIT_MISS: if (cache_req_complete_i || r_cmpl_pend) w_state_nxt = ST_REPLAY;
            ST_REPLAY:    if (w_fetch_acc) w_state_nxt = ST_RUN;
            ST_RUN, ST_HOLD: w_state_nxt = r_state;
            default:      w_state_nxt = ST_RUN;
        endcase
        if (w_fault) begin
            w_state_nxt = ST_HOLD;
        end else if (w_itlb) begin
            w_state_nxt = ST_WAIT_FILL;
        end else if (w_icmiss) begin
            w_state_nxt = ST_WAIT_MISS;
        end
        if (redirect_i) begin
            w_state_nxt = ST_RUN;
        end
    end

    // A pending fence owns the port until the pipe drains.
    always_comb begin
        mem_cmd_v_o  = 1'b0;
        mem_cmd_op_o = OP_FETCH;
        if (!reset_i) begin
            if (fence_v_i) begin
                if (!r_s1_v && !r_s2_v) begin
                    mem_cmd_v_o  = 1'b1;
                    mem_cmd_op_o = OP_FENCE;
                end
            end else if (fill_v_i) begin
                mem_cmd_v_o  = 1'b1;
                mem_cmd_op_o = OP_FILL;
            end else if (w_fetch_slot && !redirect_i && !w_kill) begin
                mem_cmd_v_o  = 1'b1;
                mem_cmd_op_o = OP_FETCH;
            end
        end
        w_fetch_acc  = mem_cmd_v_o && (mem_cmd_op_o == OP_FETCH) && mem_cmd_yumi_i;
        fetch_yumi_o = w_fetch_acc && (r_state == ST_RUN);
        fill_yumi_o  = mem_cmd_v_o && (mem_cmd_op_o == OP_FILL) && mem_cmd_yumi_i;
        fence_yumi_o = mem_cmd_v_o && (mem_cmd_op_o == OP_FENCE) && mem_cmd_yumi_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_s1_v       <= 1'b0;
            r_s2_v       <= 1'b0;
            r_s1_vaddr   <= '0;
            r_s2_vaddr   <= '0;
            r_miss_vaddr <= '0;
            r_cmpl_pend  <= 1'b0;
        end else begin
            r_cmpl_pend <= w_icmiss && cache_req_complete_i;
            r_s2_vaddr  <= r_s1_vaddr;
            if (redirect_i) begin
                r_s1_v <= 1'b0;
                r_s2_v <= 1'b0;
            end else begin
                r_s2_v <= r_s1_v && !w_kill;
                r_s1_v <= w_fetch_acc;
            end
            if (w_fetch_acc) begin
                r_s1_vaddr <= mem_cmd_vaddr_o;
            end
            if (w_kill) begin
                r_miss_vaddr <= r_s2_vaddr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_fe_mem_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_bp_fe_mem_sched
// Desc   : Self-checking bench: arbitration table, directed miss/fault/fence
//          sequences, and randomized traffic against a queue-based model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_bp_fe_mem_sched;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        fetch_v_i;
    logic [38:0] fetch_vaddr_i;
    logic        fetch_yumi_o;
    logic        fill_v_i;
    logic [26:0] fill_vtag_i;
    logic [63:0] fill_entry_i;
    logic        fill_yumi_o;
    logic        fence_v_i;
    logic        fence_yumi_o;
    logic        redirect_i;
    logic        mem_cmd_v_o;
    logic [1:0]  mem_cmd_op_o;
    logic [38:0] mem_cmd_vaddr_o;
    logic [26:0] mem_cmd_vtag_o;
    logic [63:0] mem_cmd_entry_o;
    logic        mem_cmd_yumi_i;
    logic        mem_poison_o;
    logic        mem_resp_v_i;
    logic        mem_resp_itlb_miss_i;
    logic        mem_resp_icache_miss_i;
    logic        mem_resp_fault_i;
    logic        cache_req_complete_i;
    logic        itlb_miss_v_o;
    logic        fault_v_o;
    logic [38:0] miss_vaddr_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    bp_fe_mem_sched dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .fetch_v_i(fetch_v_i), .fetch_vaddr_i(fetch_vaddr_i), .fetch_yumi_o(fetch_yumi_o),
        .fill_v_i(fill_v_i), .fill_vtag_i(fill_vtag_i), .fill_entry_i(fill_entry_i),
        .fill_yumi_o(fill_yumi_o), .fence_v_i(fence_v_i), .fence_yumi_o(fence_yumi_o),
        .redirect_i(redirect_i), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_op_o(mem_cmd_op_o),
        .mem_cmd_vaddr_o(mem_cmd_vaddr_o), .mem_cmd_vtag_o(mem_cmd_vtag_o),
        .mem_cmd_entry_o(mem_cmd_entry_o), .mem_cmd_yumi_i(mem_cmd_yumi_i),
        .mem_poison_o(mem_poison_o), .mem_resp_v_i(mem_resp_v_i),
        .mem_resp_itlb_miss_i(mem_resp_itlb_miss_i),
        .mem_resp_icache_miss_i(mem_resp_icache_miss_i),
        .mem_resp_fault_i(mem_resp_fault_i), .cache_req_complete_i(cache_req_complete_i),
        .itlb_miss_v_o(itlb_miss_v_o), .fault_v_o(fault_v_o),
        .miss_vaddr_o(miss_vaddr_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        fetch_v_i = 0; fetch_vaddr_i = '0; fill_v_i = 0; fill_vtag_i = '0;
        fill_entry_i = '0; fence_v_i = 0; redirect_i = 0; mem_cmd_yumi_i = 0;
        mem_resp_v_i = 0; mem_resp_itlb_miss_i = 0; mem_resp_icache_miss_i = 0;
        mem_resp_fault_i = 0; cache_req_complete_i = 0;
    endtask

    task automatic step();
        @(posedge clk_i); #1;
    endtask

    task automatic fetch(input logic [38:0] a);
        fetch_v_i = 1; fetch_vaddr_i = a; mem_cmd_yumi_i = 1;
    endtask

    typedef struct {
        bit fv, lv, nv, yumi, redir;
        bit ev; logic [1:0] eop; bit efy, ely, eny, epois;
    } vec_t;
    vec_t vecs[8];

    // Reference model state: in-flight fetches kept as (address, issue cycle).
    typedef struct { logic [38:0] a; int t; } fl_t;
    localparam int M_RUN = 0, M_WFILL = 1, M_WMISS = 2, M_REPLAY = 3, M_HOLD = 4;
    fl_t         pipe[$];
    int          now;
    int          mode;
    logic [38:0] mva;
    bit          pend;

    initial begin
        idle();
        reset_i = 1;
        step(); step();
        @(negedge clk_i);
        chk("rst_during_busy", 64'(busy_o), 64'd0);
        step();
        reset_i = 0;
        @(negedge clk_i);
        chk("rst_cmd_v", 64'(mem_cmd_v_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_poison", 64'(mem_poison_o), 64'd0);
        chk("rst_miss_vaddr", 64'(miss_vaddr_o), 64'd0);
        chk("rst_notify", 64'({itlb_miss_v_o, fault_v_o}), 64'd0);
        step();

        // Arbitration table, each row from an empty RUN pipe.
        vecs[0] = '{1,0,0,1,0, 1,2'd0,1,0,0,0};
        vecs[1] = '{1,0,0,0,0, 1,2'd0,0,0,0,0};
        vecs[2] = '{1,1,0,1,0, 1,2'd1,0,1,0,0};
        vecs[3] = '{1,1,1,1,0, 1,2'd2,0,0,1,0};
        vecs[4] = '{0,0,1,0,0, 1,2'd2,0,0,0,0};
        vecs[5] = '{1,0,0,1,1, 0,2'd0,0,0,0,1};
        vecs[6] = '{0,1,0,1,1, 1,2'd1,0,1,0,1};
        vecs[7] = '{0,0,0,1,0, 0,2'd0,0,0,0,0};
        for (int i = 0; i < 8; i++) begin
            idle();
            fetch_v_i = vecs[i].fv; fill_v_i = vecs[i].lv; fence_v_i = vecs[i].nv;
            mem_cmd_yumi_i = vecs[i].yumi; redirect_i = vecs[i].redir;
            fetch_vaddr_i = 39'h700 + 39'(i);
            @(negedge clk_i);
            chk($sformatf("vec%0d_cmd_v", i), 64'(mem_cmd_v_o), 64'(vecs[i].ev));
            if (vecs[i].ev) chk($sformatf("vec%0d_op", i), 64'(mem_cmd_op_o), 64'(vecs[i].eop));
            chk($sformatf("vec%0d_yumis", i), 64'({fetch_yumi_o, fill_yumi_o, fence_yumi_o}),
                64'({vecs[i].efy, vecs[i].ely, vecs[i].eny}));
            chk($sformatf("vec%0d_poison", i), 64'(mem_poison_o), 64'(vecs[i].epois));
            step();
            idle(); reset_i = 1; step(); reset_i = 0;
        end

        // 1: back-to-back clean fetches
        fetch(39'h1000);
        @(negedge clk_i);
        chk("t1_yumi0", 64'(fetch_yumi_o), 64'd1);
        chk("t1_vaddr0", 64'(mem_cmd_vaddr_o), 64'h1000);
        step(); fetch(39'h1004);
        @(negedge clk_i);
        chk("t1_yumi1", 64'(fetch_yumi_o), 64'd1);
        step(); idle(); mem_resp_v_i = 1;
        @(negedge clk_i);
        chk("t1_poison2", 64'(mem_poison_o), 64'd0);
        chk("t1_busy2", 64'(busy_o), 64'd1);
        step(); mem_resp_v_i = 1;
        @(negedge clk_i);
        chk("t1_poison3", 64'(mem_poison_o), 64'd0);
        chk("t1_busy3", 64'(busy_o), 64'd1);
        step(); idle();
        @(negedge clk_i);
        chk("t1_busy_drop", 64'(busy_o), 64'd0);
        step();

        // 2: ITLB miss, fill, replay
        fetch(39'h2000); step(); fetch(39'h2004); step();
        fetch(39'h2008); mem_resp_v_i = 1; mem_resp_itlb_miss_i = 1;
        @(negedge clk_i);
        chk("t2_itlb_v", 64'(itlb_miss_v_o), 64'd1);
        chk("t2_miss_vaddr", 64'(miss_vaddr_o), 64'h2000);
        chk("t2_poison", 64'(mem_poison_o), 64'd1);
        chk("t2_no_fetch", 64'(fetch_yumi_o), 64'd0);
        step(); idle(); fetch(39'h2008);
        @(negedge clk_i);
        chk("t2_wait_cmd_v", 64'(mem_cmd_v_o), 64'd0);
        chk("t2_miss_vaddr_hold", 64'(miss_vaddr_o), 64'h2000);
        step(); idle(); fill_v_i = 1; fill_vtag_i = 27'h123; fill_entry_i = 64'hdead_beef;
        mem_cmd_yumi_i = 1;
        @(negedge clk_i);
        chk("t2_fill_yumi", 64'(fill_yumi_o), 64'd1);
        chk("t2_fill_tag", 64'(mem_cmd_vtag_o), 64'h123);
        step(); idle(); mem_cmd_yumi_i = 1;
        @(negedge clk_i);
        chk("t2_replay_v", 64'(mem_cmd_v_o), 64'd1);
        chk("t2_replay_op", 64'(mem_cmd_op_o), 64'd0);
        chk("t2_replay_vaddr", 64'(mem_cmd_vaddr_o), 64'h2000);
        chk("t2_replay_ext_yumi", 64'(fetch_yumi_o), 64'd0);
        step(); idle(); fetch(39'h2004);
        @(negedge clk_i);
        chk("t2_run_again", 64'(fetch_yumi_o), 64'd1);
        step(); idle(); step(); step(); step();

        // 3: I$ miss with completion ten cycles later
        fetch(39'h3000); step(); idle(); step();
        mem_resp_v_i = 1; mem_resp_icache_miss_i = 1;
        @(negedge clk_i);
        chk("t3_poison", 64'(mem_poison_o), 64'd1);
        chk("t3_notify", 64'({itlb_miss_v_o, fault_v_o}), 64'd0);
        step(); idle();
        for (int i = 0; i < 10; i++) begin
            fetch(39'h3100); cache_req_complete_i = (i == 9);
            @(negedge clk_i);
            chk($sformatf("t3_wait%0d", i), 64'(mem_cmd_v_o), 64'd0);
            step();
        end
        idle(); mem_cmd_yumi_i = 1;
        @(negedge clk_i);
        chk("t3_replay_v", 64'(mem_cmd_v_o), 64'd1);
        chk("t3_replay_vaddr", 64'(mem_cmd_vaddr_o), 64'h3000);
        chk("t3_replay_op", 64'(mem_cmd_op_o), 64'd0);
        step(); idle(); step(); step(); step();

        // 4: fence waits for an empty pipe
        fetch(39'h5000); step();
        fetch(39'h5004); fence_v_i = 1;
        @(negedge clk_i);
        chk("t4_blk1", 64'({fetch_yumi_o, mem_cmd_v_o, fence_yumi_o}), 64'd0);
        step();
        @(negedge clk_i);
        chk("t4_blk2", 64'({fetch_yumi_o, mem_cmd_v_o, fence_yumi_o}), 64'd0);
        step();
        @(negedge clk_i);
        chk("t4_fence_yumi", 64'(fence_yumi_o), 64'd1);
        chk("t4_fence_op", 64'(mem_cmd_op_o), 64'd2);
        step(); idle();

        // 5: fault, hold, redirect
        fetch(39'h4000); step(); idle(); step();
        mem_resp_v_i = 1; mem_resp_fault_i = 1; mem_resp_itlb_miss_i = 1;
        @(negedge clk_i);
        chk("t5_fault_v", 64'(fault_v_o), 64'd1);
        chk("t5_itlb_masked", 64'(itlb_miss_v_o), 64'd0);
        chk("t5_miss_vaddr", 64'(miss_vaddr_o), 64'h4000);
        step(); idle();
        for (int i = 0; i < 20; i++) begin
            fetch(39'h4100);
            @(negedge clk_i);
            chk($sformatf("t5_hold%0d", i), 64'({mem_cmd_v_o, fault_v_o}), 64'd0);
            step();
        end
        redirect_i = 1;
        @(negedge clk_i);
        chk("t5_redir_poison", 64'(mem_poison_o), 64'd1);
        chk("t5_redir_nofetch", 64'(fetch_yumi_o), 64'd0);
        step(); redirect_i = 0;
        @(negedge clk_i);
        chk("t5_run_fetch", 64'(fetch_yumi_o), 64'd1);
        step(); idle(); step(); step(); step();

        // 6: redirect drops a coincident I$ miss
        fetch(39'h6000); step(); idle(); step();
        mem_resp_v_i = 1; mem_resp_icache_miss_i = 1; redirect_i = 1;
        @(negedge clk_i);
        chk("t6_poison", 64'(mem_poison_o), 64'd1);
        step(); idle();
        @(negedge clk_i);
        chk("t6_busy", 64'(busy_o), 64'd0);
        step(); fetch(39'h6100);
        @(negedge clk_i);
        chk("t6_fetch_yumi", 64'(fetch_yumi_o), 64'd1);
        chk("t6_vaddr", 64'(mem_cmd_vaddr_o), 64'h6100);
        step(); idle(); step(); step(); step();

        // Randomized traffic against the reference model
        reset_i = 1; step(); reset_i = 0;
        pipe.delete(); now = 0; mode = M_RUN; mva = '0; pend = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bit s1h, s2h, empty, resp, ef, ei, ec, kill, want, ev, afetch, afill;
            logic [1:0]  eop;
            logic [38:0] s2a, faddr;
            fl_t e;
            reset_i = ($urandom_range(0, 149) == 0);
            fetch_v_i = ($urandom_range(0, 3) != 0);
            fetch_vaddr_i = {7'($urandom), 32'($urandom)};
            fill_v_i = ($urandom_range(0, 5) == 0);
            fill_vtag_i = 27'($urandom);
            fill_entry_i = {32'($urandom), 32'($urandom)};
            fence_v_i = ($urandom_range(0, 7) == 0);
            redirect_i = ($urandom_range(0, 15) == 0);
            mem_cmd_yumi_i = ($urandom_range(0, 3) != 0);
            mem_resp_v_i = ($urandom_range(0, 3) != 0);
            mem_resp_itlb_miss_i = ($urandom_range(0, 7) == 0);
            mem_resp_icache_miss_i = ($urandom_range(0, 7) == 0);
            mem_resp_fault_i = ($urandom_range(0, 11) == 0);
            cache_req_complete_i = ($urandom_range(0, 7) == 0);
            @(negedge clk_i);
            s1h = 0; s2h = 0; s2a = '0;
            foreach (pipe[k]) begin
                if (now - pipe[k].t == 1) s1h = 1;
                if (now - pipe[k].t == 2) begin s2h = 1; s2a = pipe[k].a; end
            end
            empty = !s1h && !s2h;
            resp = !reset_i && s2h && mem_resp_v_i && !redirect_i;
            ef = resp && mem_resp_fault_i;
            ei = resp && !mem_resp_fault_i && mem_resp_itlb_miss_i;
            ec = resp && !mem_resp_fault_i && !mem_resp_itlb_miss_i && mem_resp_icache_miss_i;
            kill = ef || ei || ec;
            want = (mode == M_RUN && fetch_v_i) || mode == M_REPLAY;
            faddr = (mode == M_REPLAY) ? mva : fetch_vaddr_i;
            ev = 0; eop = 2'd0;
            if (!reset_i) begin
                if (fence_v_i) begin ev = empty; eop = 2'd2; end
                else if (fill_v_i) begin ev = 1; eop = 2'd1; end
                else if (want && !redirect_i && !kill) begin ev = 1; eop = 2'd0; end
            end
            afetch = ev && eop == 2'd0 && mem_cmd_yumi_i;
            afill  = ev && eop == 2'd1 && mem_cmd_yumi_i;
            chk($sformatf("rnd%0d_cmd_v", cyc), 64'(mem_cmd_v_o), 64'(ev));
            if (ev) chk($sformatf("rnd%0d_op", cyc), 64'(mem_cmd_op_o), 64'(eop));
            if (ev && eop == 2'd0) chk($sformatf("rnd%0d_vaddr", cyc), 64'(mem_cmd_vaddr_o), 64'(faddr));
            if (ev && eop == 2'd1) chk($sformatf("rnd%0d_fill_data", cyc),
                64'({mem_cmd_vtag_o, mem_cmd_entry_o[31:0]}), 64'({fill_vtag_i, fill_entry_i[31:0]}));
            chk($sformatf("rnd%0d_yumis", cyc), 64'({fetch_yumi_o, fill_yumi_o, fence_yumi_o}),
                64'({afetch && mode == M_RUN, afill, ev && eop == 2'd2 && mem_cmd_yumi_i}));
            chk($sformatf("rnd%0d_poison", cyc), 64'(mem_poison_o), 64'(!reset_i && (redirect_i || kill)));
            chk($sformatf("rnd%0d_notify", cyc), 64'({itlb_miss_v_o, fault_v_o}), 64'({ei, ef}));
            chk($sformatf("rnd%0d_miss_vaddr", cyc), 64'(miss_vaddr_o), 64'(kill ? s2a : mva));
            chk($sformatf("rnd%0d_busy", cyc), 64'(busy_o), 64'(!reset_i && (!empty || mode != M_RUN)));
            @(posedge clk_i);
            if (reset_i) begin
                pipe.delete(); mode = M_RUN; mva = '0; pend = 0;
            end else if (redirect_i) begin
                pipe.delete(); mode = M_RUN; pend = 0;
            end else if (kill) begin
                pipe.delete(); mva = s2a;
                mode = ef ? M_HOLD : (ei ? M_WFILL : M_WMISS);
                pend = ec && cache_req_complete_i;
            end else begin
                if (mode == M_WFILL && afill) mode = M_REPLAY;
                else if (mode == M_WMISS && (cache_req_complete_i || pend)) mode = M_REPLAY;
                else if (mode == M_REPLAY && afetch) mode = M_RUN;
                pend = 0;
                if (afetch) begin e.a = faddr; e.t = now; pipe.push_back(e); end
            end
            now++;
            while (pipe.size() > 0 && now - pipe[0].t > 2) void'(pipe.pop_front());
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
